// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian crossing controller downstream of the
// traffic-light FSM. It debounces the push-button, latches a crossing request,
// and runs WALK -> FLASH -> STOP on each RED entry that has a request waiting.
// It also locks into a safe STOP with a sticky fault when the vehicle lamps are
// not one-hot.
// Optional feature: define PED_COUNTDOWN_EN to add the 8-bit `countdown` port.
module ped_crossing_ctrl #(
    parameter int DEBOUNCE     = 4,
    parameter int WALK_CYCLES  = 20,
    parameter int FLASH_CYCLES = 10,
    parameter int FLASH_HALF   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       button,
    output logic       walk,
    output logic       dont_walk,
    output logic       request_pending,
    output logic       fault
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [7:0] countdown
`endif
);

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_WALK  = 2'd1;
    localparam logic [1:0] ST_FLASH = 2'd2;

    localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE - 1);
    localparam logic [7:0] WALK_LAST  = 8'(WALK_CYCLES - 1);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_CYCLES - 1);
    localparam logic [7:0] HALF_LAST  = 8'(FLASH_HALF - 1);

    logic       meta_q, sb_q;
    logic       deb_q, deb_d;
    logic [7:0] deb_cnt_q, deb_cnt_d;
    logic       press_q, press_d;
    logic       red_q;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] half_q, half_d;
    logic       req_q, req_d;
    logic       fault_q, fault_d;
    logic       walk_q, walk_d;
    logic       dw_q, dw_d;
    logic       start;
    logic       illegal;
    logic       red_rise;

    assign illegal  = !(({red, yellow, green} == 3'b100) ||
                        ({red, yellow, green} == 3'b010) ||
                        ({red, yellow, green} == 3'b001));
    assign red_rise = red & ~red_q;

    // Two-flop synchronizer for the asynchronous button, plus the red history.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sb_q   <= 1'b0;
            red_q  <= 1'b0;
        end else begin
            meta_q <= button;
            sb_q   <= meta_q;
            red_q  <= red;
        end
    end

    // Debounce: flip the accepted level after DEBOUNCE differing samples in a row.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = 8'd0;
        press_d   = 1'b0;
        if (sb_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d   = ~deb_q;
                press_d = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 8'd1;
            end
        end
    end

    // Crossing sequencer with fault > abort > normal-transition priority.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        fault_d = fault_q;
        start   = 1'b0;
        if (fault_q || illegal) begin
            fault_d = 1'b1;
            state_d = ST_STOP;
            req_d   = 1'b0;
        end else begin
            if (state_q != ST_STOP && !red) begin
                state_d = ST_STOP;
            end else begin
                case (state_q)
                    ST_STOP:  if (red_rise && (req_q || press_q)) begin
                                  state_d = ST_WALK;
                                  start   = 1'b1;
                              end
                    ST_WALK:  if (cnt_q == WALK_LAST) state_d = ST_FLASH;
                    ST_FLASH: if (cnt_q == FLASH_LAST) state_d = ST_STOP;
                    default:  state_d = ST_STOP;
                endcase
            end
            // A press in the starting cycle is consumed by that crossing.
            if (start) begin
                req_d = 1'b0;
            end else if (press_q && state_q != ST_WALK) begin
                req_d = 1'b1;
            end
        end
    end

    // Phase counter, blink timer and registered lamp outputs from the next state.
    always_comb begin
        cnt_d  = (state_d == state_q && state_q != ST_STOP) ? cnt_q + 8'd1 : 8'd0;
        half_d = 8'd0;
        walk_d = (state_d == ST_WALK);
        dw_d   = 1'b1;
        case (state_d)
            ST_WALK: dw_d = 1'b0;
            ST_FLASH: begin
                if (state_q != ST_FLASH) begin
                    dw_d = 1'b1;
                end else if (half_q == HALF_LAST) begin
                    dw_d = ~dw_q;
                end else begin
                    dw_d   = dw_q;
                    half_d = half_q + 8'd1;
                end
            end
            default: dw_d = 1'b1;
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= 8'd0;
            press_q   <= 1'b0;
            state_q   <= ST_STOP;
            cnt_q     <= 8'd0;
            half_q    <= 8'd0;
            req_q     <= 1'b0;
            fault_q   <= 1'b0;
            walk_q    <= 1'b0;
            dw_q      <= 1'b1;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            req_q     <= req_d;
            fault_q   <= fault_d;
            walk_q    <= walk_d;
            dw_q      <= dw_d;
        end
    end

    assign walk            = walk_q;
    assign dont_walk       = dw_q;
    assign request_pending = req_q;
    assign fault           = fault_q;

`ifdef PED_COUNTDOWN_EN
    localparam logic [7:0] CD_LOAD = 8'(WALK_CYCLES + FLASH_CYCLES);

    logic [7:0] cd_q, cd_d;

    // Remaining crossing cycles: loaded on WALK entry, reaches 1 in the last FLASH cycle.
    always_comb begin
        cd_d = 8'd0;
        if (state_d == ST_WALK && state_q != ST_WALK) begin
            cd_d = CD_LOAD;
        end else if (state_d != ST_STOP) begin
            cd_d = cd_q - 8'd1;
        end
    end

    // Countdown register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cd_q <= 8'd0;
        end else begin
            cd_q <= cd_d;
        end
    end

    assign countdown = cd_q;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Testbench for ped_crossing_ctrl: directed scenarios plus randomized lamp and
// button traffic, compared each cycle against a timeline-based reference model.
module tb_ped_crossing_ctrl;

    localparam int DEB = 4;
    localparam int W   = 20;
    localparam int F   = 10;
    localparam int FH  = 2;
    localparam int WF  = W + F;

    logic clk = 1'b0;
    logic reset, red, yellow, green, button;
    logic walk, dont_walk, request_pending, fault;
`ifdef PED_COUNTDOWN_EN
    logic [7:0] countdown;
`endif

    always #5 clk = ~clk;

    ped_crossing_ctrl #(
        .DEBOUNCE(DEB), .WALK_CYCLES(W), .FLASH_CYCLES(F), .FLASH_HALF(FH)
    ) dut (
        .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
        .button(button), .walk(walk), .dont_walk(dont_walk),
        .request_pending(request_pending), .fault(fault)
`ifdef PED_COUNTDOWN_EN
        , .countdown(countdown)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (timeline arithmetic) ----------------
    int k;              // index of the next non-reset clock edge
    bit blog[$];        // button value sampled at each edge since reset
    bit m_deb, m_press_pend, m_red_prev, m_fault, m_req;
    int m_s;            // edge at which the current/last crossing started, -1 none
    int e_walk, e_dw, e_req, e_fault, e_cd;

    function automatic bit sb_at(int e);
        return (e >= 2) ? blog[e-2] : 1'b0;
    endfunction

    task automatic model_edge(input bit b, input bit [2:0] lamps, input bit rst);
        bit press_now, tog, rr, illegal, act_b, walk_b, started, active;
        int p;
        if (rst) begin
            k = 0; blog.delete();
            m_deb = 0; m_press_pend = 0; m_red_prev = 0; m_fault = 0; m_req = 0; m_s = -1;
            e_walk = 0; e_dw = 1; e_req = 0; e_fault = 0; e_cd = 0;
            return;
        end
        blog.push_back(b);
        press_now = m_press_pend;
        tog = 1;
        for (int j = 0; j < DEB; j++)
            if (k - j < 0 || sb_at(k - j) == m_deb) tog = 0;
        m_press_pend = tog && !m_deb;
        if (tog) m_deb = !m_deb;
        rr = lamps[2] && !m_red_prev;
        m_red_prev = lamps[2];
        illegal = !(lamps == 3'b100 || lamps == 3'b010 || lamps == 3'b001);
        act_b  = (m_s >= 0) && (k - 1 - m_s < WF);
        walk_b = act_b && (k - 1 - m_s < W);
        started = 0;
        if (illegal || m_fault) begin
            m_fault = 1; m_s = -1; m_req = 0;
        end else begin
            if (act_b && !lamps[2]) m_s = -1;
            else if (!act_b && rr && (m_req || press_now)) begin m_s = k; started = 1; end
            if (started) m_req = 0;
            else if (press_now && !walk_b) m_req = 1;
        end
        p = k - m_s;
        active = (m_s >= 0) && (p < WF);
        e_walk  = (active && p < W) ? 1 : 0;
        e_dw    = !active ? 1 : (p < W ? 0 : ((((p - W) / FH) % 2) == 0 ? 1 : 0));
        e_cd    = active ? WF - p : 0;
        e_req   = m_req;
        e_fault = m_fault;
        k++;
    endtask

    // One clock: drive inputs at the falling edge, compare after the next one.
    task automatic step(input bit b, input bit [2:0] lamps, input bit rst);
        button = b; {red, yellow, green} = lamps; reset = rst;
        model_edge(b, lamps, rst);
        @(negedge clk);
        chk("walk", 32'(walk), e_walk);
        chk("dont_walk", 32'(dont_walk), e_dw);
        chk("request_pending", 32'(request_pending), e_req);
        chk("fault", 32'(fault), e_fault);
`ifdef PED_COUNTDOWN_EN
        chk("countdown", 32'(countdown), e_cd);
`endif
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_walk"}, 32'(walk), 0);
        chk({tag, "_dont_walk"}, 32'(dont_walk), 1);
        chk({tag, "_req"}, 32'(request_pending), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
`ifdef PED_COUNTDOWN_EN
        chk({tag, "_countdown"}, 32'(countdown), 0);
`endif
    endtask

    // ---------------- random traffic generators ----------------
    int lt = 2, lt_left = 0;
    int bt_left = 0, bt_age = 0;
    bit bt_level = 0;

    task automatic next_lamps(output bit [2:0] l);
        if (lt_left == 0) begin
            lt = (lt + 1) % 3;
            lt_left = (lt == 2) ? int'($urandom_range(3, 60)) :
                      (lt == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(2, 20));
        end
        lt_left--;
        l = (lt == 0) ? 3'b001 : (lt == 1) ? 3'b010 : 3'b100;
    endtask

    task automatic next_button(output bit b);
        if (bt_left == 0) begin
            bt_level = 1'($urandom_range(0, 1));
            bt_left = $urandom_range(1, 40);
            bt_age = 0;
        end
        bt_left--;
        b = (bt_age < 3 && $urandom_range(0, 1) == 1) ? !bt_level : bt_level;
        bt_age++;
    endtask

    task automatic random_run(input int n, input bit with_faults);
        bit [2:0] l;
        bit b, r;
        bit [2:0] bad;
        for (int i = 0; i < n; i++) begin
            next_lamps(l);
            next_button(b);
            r = 0;
            if (with_faults) begin
                if ($urandom_range(0, 299) == 0) begin
                    bad = 3'($urandom_range(0, 7));
                    if (bad == 3'b100 || bad == 3'b010 || bad == 3'b001) bad = 3'b000;
                    l = bad;
                end
                r = ($urandom_range(0, 399) == 0);
            end
            step(b, l, r);
        end
    endtask

    // ---------------- scenario sequence ----------------
    initial begin
        int lat, wcnt;
        logic [9:0] fl_pat;
        button = 0; {red, yellow, green} = 3'b001; reset = 1;

        step(0, 3'b001, 1);
        step(0, 3'b001, 1);
        chk_reset_vals("reset");

        // Bouncy press: 1,0,1,0 then hold high on green.
        for (int i = 0; i < 10; i++) step(0, 3'b001, 0);
        step(1, 3'b001, 0); step(0, 3'b001, 0); step(1, 3'b001, 0); step(0, 3'b001, 0);
        lat = -1;
        for (int i = 0; i < 16; i++) begin
            step(1, 3'b001, 0);
            if (request_pending && lat < 0) lat = i + 1;
        end
        chk("deb_latency", lat, DEB + 3);

        // Normal crossing on the next red entry.
        step(1, 3'b010, 0); step(1, 3'b010, 0);
        fl_pat = 10'b1100110011;
        wcnt = 0;
        for (int i = 0; i < 45; i++) begin
            step(1, 3'b100, 0);
            if (walk) wcnt++;
            if (i == 0) begin
                chk("start_walk", 32'(walk), 1);
                chk("start_req_clr", 32'(request_pending), 0);
            end
            if (i >= 20 && i < 30) chk("flash_pat", 32'(dont_walk), 32'(fl_pat[29 - i]));
            if (i == 30) chk("end_stop", 32'({walk, dont_walk}), 1);
        end
        chk("walk_cycles", wcnt, W);

        // No requests: full light cycles, walk must never light.
        wcnt = 0;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 12; i++) begin step(0, 3'b001, 0); if (walk) wcnt++; end
            for (int i = 0; i < 3; i++)  begin step(0, 3'b010, 0); if (walk) wcnt++; end
            for (int i = 0; i < 35; i++) begin step(0, 3'b100, 0); if (walk || !dont_walk) wcnt++; end
        end
        chk("no_request_walk", wcnt, 0);

        lt = 2; lt_left = 0;
        random_run(3000, 0);

        // Abort: red drops after 5 WALK cycles.
        for (int i = 0; i < 40; i++) step(0, 3'b001, 0);
        for (int i = 0; i < 10; i++) step(1, 3'b001, 0);
        step(0, 3'b001, 0); step(0, 3'b001, 0); step(0, 3'b010, 0);
        for (int i = 0; i < 5; i++) step(0, 3'b100, 0);
        chk("abort_pre_walk", 32'(walk), 1);
        step(0, 3'b001, 0);
        chk("abort_walk", 32'(walk), 0);
        chk("abort_dw", 32'(dont_walk), 1);
        chk("abort_fault", 32'(fault), 0);

        // Fault: red+green during WALK, then presses are ignored, reset clears.
        for (int i = 0; i < 10; i++) step(0, 3'b001, 0);
        for (int i = 0; i < 10; i++) step(1, 3'b001, 0);
        step(1, 3'b010, 0);
        for (int i = 0; i < 3; i++) step(1, 3'b100, 0);
        step(1, 3'b101, 0);
        chk("fault_set", 32'(fault), 1);
        chk("fault_stop", 32'({walk, dont_walk}), 1);
        for (int i = 0; i < 10; i++) step(0, 3'b100, 0);
        for (int i = 0; i < 12; i++) step(1, 3'b001, 0);
        chk("fault_no_req", 32'(request_pending), 0);
        chk("fault_sticky", 32'(fault), 1);
        step(1, 3'b001, 1);
        chk_reset_vals("fault_reset");

        // Press arriving in the same cycle as the red rise.
        for (int i = 0; i < 12; i++) step(0, 3'b001, 0);
        for (int i = 0; i < 5; i++) step(1, 3'b001, 0);
        step(1, 3'b010, 0);
        step(1, 3'b100, 0);
        chk("simul_walk", 32'(walk), 1);
        chk("simul_req", 32'(request_pending), 0);
        for (int i = 0; i < 35; i++) step(1, 3'b100, 0);
        chk("simul_residual", 32'(request_pending), 0);
        wcnt = 0;
        for (int i = 0; i < 5; i++) step(1, 3'b001, 0);
        step(1, 3'b010, 0);
        for (int i = 0; i < 25; i++) begin step(1, 3'b100, 0); if (walk) wcnt++; end
        chk("simul_no_second", wcnt, 0);

        // Reset in the middle of FLASH.
        for (int i = 0; i < 10; i++) step(0, 3'b001, 0);
        for (int i = 0; i < 10; i++) step(1, 3'b001, 0);
        step(1, 3'b010, 0);
        for (int i = 0; i < 25; i++) step(1, 3'b100, 0);
        chk("pre_reset_flash", 32'(walk), 0);
        step(1, 3'b100, 1);
        chk_reset_vals("flash_reset");

        lt = 2; lt_left = 0;
        random_run(2500, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
